// File: rtl/t03_multicycle_control_if.sv
// Instruction/data bus handshake between the multi-cycle control unit and the memory side.
interface t03_multicycle_control_if;
    logic        imem_req;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        dmem_read;
    logic        dmem_write;
    logic        dmem_ack;

    modport master (output imem_req, dmem_read, dmem_write,
                    input  imem_ack, imem_rdata, dmem_ack);
    modport slave  (input  imem_req, dmem_read, dmem_write,
                    output imem_ack, imem_rdata, dmem_ack);
endinterface

// File: rtl/t03_multicycle_control.sv
// Multi-cycle RV32I control unit: FETCH/DECODE/EXEC/MEM/WB sequencing with a registered
// control word, bus-timeout and illegal-instruction traps.
module t03_multicycle_control #(
    parameter int MEM_TIMEOUT = 255
) (
    input  logic                            clk,
    input  logic                            nRst,
    input  logic                            freeze,
    input  logic                            trap_clear,
    t03_multicycle_control_if.master        bus,
    output logic [31:0]                     instr,
    output logic [3:0]                      alu_op,
    output logic [2:0]                      branch_type,
    output logic                            alu_mux_en,
    output logic                            mem_to_reg,
    output logic                            load_byte,
    output logic                            store_byte,
    output logic                            slt,
    output logic                            u,
    output logic                            read_next_pc,
    output logic                            pc_add_write_value,
    output logic                            reg_write_en,
    output logic                            pc_en,
    output logic                            illegal_instr,
    output logic                            bus_error,
    output logic [2:0]                      state
);
    localparam int TO_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(MEM_TIMEOUT - 1);

    localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_XOR = 4'd2, ALU_OR  = 4'd3,
                           ALU_AND = 4'd4, ALU_SLL = 4'd5, ALU_SRL = 4'd6, ALU_SRA = 4'd7,
                           ALU_IMM = 4'd8;
    localparam logic [2:0] BR_BEQ = 3'd1, BR_BNE = 3'd2, BR_BLT = 3'd3, BR_BGE = 3'd4,
                           BR_BLTU = 3'd5, BR_BGEU = 3'd6, BR_JMP = 3'd7;

    typedef enum logic [2:0] {
        S_FETCH = 3'd0, S_DECODE = 3'd1, S_EXEC = 3'd2, S_MEM = 3'd3, S_WB = 3'd4, S_TRAP = 3'd5
    } state_t;

    typedef struct packed {
        logic [3:0] alu_op;
        logic [2:0] br;
        logic       mux, m2r, lb, sb, slt, u, rnp, pawv;
        logic       rw, ld, st;
    } ctrl_t;

    state_t          state_q, state_d;
    logic [TO_W-1:0] cnt_q, cnt_d;
    logic [31:0]     instr_q, instr_d;
    ctrl_t           ctrl_q, ctrl_d, dec;
    logic            ill_q, ill_d, be_q, be_d, dec_ok;
    logic [6:0]      opc;
    logic [2:0]      f3;
    logic            f7b5;

    assign opc  = instr_q[6:0];
    assign f3   = instr_q[14:12];
    assign f7b5 = instr_q[30];

    // Decode key {funct7[5], funct3, opcode}; funct7[5] only matters for R-type and SRLI/SRAI.
    always_comb begin
        dec    = '0;
        dec_ok = 1'b1;
        case (opc)
            7'b0110011: begin
                dec.rw = 1'b1;
                case (f3)
                    3'd0: dec.alu_op = f7b5 ? ALU_SUB : ALU_ADD;
                    3'd1: begin dec.alu_op = ALU_SLL; dec_ok = !f7b5; end
                    3'd2: begin dec.alu_op = ALU_SUB; dec.slt = 1'b1; dec_ok = !f7b5; end
                    3'd3: begin dec.alu_op = ALU_SUB; dec.slt = 1'b1; dec.u = 1'b1; dec_ok = !f7b5; end
                    3'd4: begin dec.alu_op = ALU_XOR; dec_ok = !f7b5; end
                    3'd5: dec.alu_op = f7b5 ? ALU_SRA : ALU_SRL;
                    3'd6: begin dec.alu_op = ALU_OR; dec_ok = !f7b5; end
                    default: begin dec.alu_op = ALU_AND; dec_ok = !f7b5; end
                endcase
            end
            7'b0010011: begin
                dec.rw  = 1'b1;
                dec.mux = 1'b1;
                case (f3)
                    3'd0: dec.alu_op = ALU_ADD;
                    3'd1: dec.alu_op = ALU_SLL;
                    3'd2: begin dec.alu_op = ALU_SUB; dec.slt = 1'b1; end
                    3'd3: begin dec.alu_op = ALU_SUB; dec.slt = 1'b1; dec.u = 1'b1; end
                    3'd4: dec.alu_op = ALU_XOR;
                    3'd5: dec.alu_op = f7b5 ? ALU_SRA : ALU_SRL;
                    3'd6: dec.alu_op = ALU_OR;
                    default: dec.alu_op = ALU_AND;
                endcase
            end
            7'b0000011: begin
                dec.rw  = 1'b1;
                dec.mux = 1'b1;
                dec.m2r = 1'b1;
                dec.ld  = 1'b1;
                dec.lb  = (f3 == 3'd0);
                dec_ok  = (f3 == 3'd0) || (f3 == 3'd2);
            end
            7'b0100011: begin
                dec.mux = 1'b1;
                dec.st  = 1'b1;
                dec.sb  = (f3 == 3'd0);
                dec_ok  = (f3 == 3'd0) || (f3 == 3'd2);
            end
            7'b1100011: begin
                dec.alu_op = ALU_SUB;
                case (f3)
                    3'd0: dec.br = BR_BEQ;
                    3'd1: dec.br = BR_BNE;
                    3'd4: dec.br = BR_BLT;
                    3'd5: dec.br = BR_BGE;
                    3'd6: begin dec.br = BR_BLTU; dec.u = 1'b1; end
                    3'd7: begin dec.br = BR_BGEU; dec.u = 1'b1; end
                    default: dec_ok = 1'b0;
                endcase
            end
            7'b0110111: begin dec.alu_op = ALU_IMM; dec.mux = 1'b1; dec.rw = 1'b1; end
            7'b0010111: begin dec.mux = 1'b1; dec.rnp = 1'b1; dec.pawv = 1'b1; dec.rw = 1'b1; end
            7'b1101111: begin dec.br = BR_JMP; dec.rnp = 1'b1; dec.rw = 1'b1; end
            7'b1100111: begin
                dec.br   = BR_JMP;
                dec.mux  = 1'b1;
                dec.rnp  = 1'b1;
                dec.pawv = 1'b1;
                dec.rw   = 1'b1;
                dec_ok   = (f3 == 3'd0);
            end
            default: dec_ok = 1'b0;
        endcase
    end

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        instr_d        = instr_q;
        ctrl_d         = ctrl_q;
        ill_d          = ill_q;
        be_d           = be_q;
        bus.imem_req   = 1'b0;
        bus.dmem_read  = 1'b0;
        bus.dmem_write = 1'b0;
        reg_write_en   = 1'b0;
        pc_en          = 1'b0;
        case (state_q)
            S_FETCH: if (!freeze) begin
                bus.imem_req = 1'b1;
                if (bus.imem_ack) begin
                    instr_d = bus.imem_rdata;
                    state_d = S_DECODE;
                end else if (cnt_q == TO_LAST) begin
                    be_d    = 1'b1;
                    state_d = S_TRAP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DECODE: begin
                if (dec_ok) begin
                    ctrl_d  = dec;
                    state_d = S_EXEC;
                end else begin
                    ctrl_d  = '0;
                    ill_d   = 1'b1;
                    state_d = S_TRAP;
                end
            end
            S_EXEC: begin
                cnt_d   = '0;
                state_d = (ctrl_q.ld || ctrl_q.st) ? S_MEM : S_WB;
            end
            S_MEM: begin
                bus.dmem_read  = ctrl_q.ld;
                bus.dmem_write = ctrl_q.st;
                if (bus.dmem_ack) begin
                    state_d = S_WB;
                end else if (cnt_q == TO_LAST) begin
                    be_d    = 1'b1;
                    state_d = S_TRAP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_WB: begin
                pc_en        = 1'b1;
                reg_write_en = ctrl_q.rw;
                cnt_d        = '0;
                state_d      = S_FETCH;
            end
            S_TRAP: if (trap_clear) begin
                ill_d   = 1'b0;
                be_d    = 1'b0;
                cnt_d   = '0;
                state_d = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state_q <= S_FETCH;
            cnt_q   <= '0;
            instr_q <= '0;
            ctrl_q  <= '0;
            ill_q   <= 1'b0;
            be_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            instr_q <= instr_d;
            ctrl_q  <= ctrl_d;
            ill_q   <= ill_d;
            be_q    <= be_d;
        end
    end

    assign state              = state_q;
    assign instr              = instr_q;
    assign alu_op             = ctrl_q.alu_op;
    assign branch_type        = ctrl_q.br;
    assign alu_mux_en         = ctrl_q.mux;
    assign mem_to_reg         = ctrl_q.m2r;
    assign load_byte          = ctrl_q.lb;
    assign store_byte         = ctrl_q.sb;
    assign slt                = ctrl_q.slt;
    assign u                  = ctrl_q.u;
    assign read_next_pc       = ctrl_q.rnp;
    assign pc_add_write_value = ctrl_q.pawv;
    assign illegal_instr      = ill_q;
    assign bus_error          = be_q;
endmodule

// File: tb/tb_t03_multicycle_control.sv
// Directed bench: each instruction's expected per-cycle trace is built from its class, wait
// counts and a hand-written control word, and a negedge process compares the DUT against it.
module tb_t03_multicycle_control;
    localparam int TO = 4;
    localparam int K_ALU = 0, K_LD = 1, K_ST = 2, K_ILL = 3;
    localparam logic [2:0] S_FETCH = 3'd0, S_DECODE = 3'd1, S_EXEC = 3'd2, S_MEM = 3'd3,
                           S_WB = 3'd4, S_TRAP = 3'd5;

    typedef struct packed {
        logic [2:0]  st;
        logic        ireq, drd, dwr, rwe, pce, ill, be;
        logic [14:0] cw;
        logic [31:0] ins;
    } exp_t;

    typedef struct {
        string nm;
        int    got;
        int    want;
    } pin_t;

    logic        clk = 1'b0;
    logic        nRst, freeze, trap_clear;
    logic [31:0] instr;
    logic [3:0]  alu_op;
    logic [2:0]  branch_type, state;
    logic        alu_mux_en, mem_to_reg, load_byte, store_byte, slt, u, read_next_pc;
    logic        pc_add_write_value, reg_write_en, pc_en, illegal_instr, bus_error;

    exp_t        expq[$];
    pin_t        pinq[$];
    logic [14:0] m_cw;
    logic [31:0] m_ins;
    logic        m_ill, m_be;
    int          errors = 0;
    int          checks = 0;
    int          lat;

    t03_multicycle_control_if bus ();

    t03_multicycle_control #(.MEM_TIMEOUT(TO)) dut (
        .clk(clk), .nRst(nRst), .freeze(freeze), .trap_clear(trap_clear), .bus(bus),
        .instr(instr), .alu_op(alu_op), .branch_type(branch_type), .alu_mux_en(alu_mux_en),
        .mem_to_reg(mem_to_reg), .load_byte(load_byte), .store_byte(store_byte), .slt(slt),
        .u(u), .read_next_pc(read_next_pc), .pc_add_write_value(pc_add_write_value),
        .reg_write_en(reg_write_en), .pc_en(pc_en), .illegal_instr(illegal_instr),
        .bus_error(bus_error), .state(state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s at %0t: got %0h, want %0h", nm, $time, got, want);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        pin_t p;
        if (expq.size() > 0) begin
            e = expq.pop_front();
            chk("state", 32'(state), 32'(e.st));
            chk("imem_req", 32'(bus.imem_req), 32'(e.ireq));
            chk("dmem_read", 32'(bus.dmem_read), 32'(e.drd));
            chk("dmem_write", 32'(bus.dmem_write), 32'(e.dwr));
            chk("reg_write_en", 32'(reg_write_en), 32'(e.rwe));
            chk("pc_en", 32'(pc_en), 32'(e.pce));
            chk("illegal_instr", 32'(illegal_instr), 32'(e.ill));
            chk("bus_error", 32'(bus_error), 32'(e.be));
            chk("ctrl_word", 32'({alu_op, branch_type, alu_mux_en, mem_to_reg, load_byte,
                                  store_byte, slt, u, read_next_pc, pc_add_write_value}),
                32'(e.cw));
            chk("instr", instr, e.ins);
        end
        while (pinq.size() > 0) begin
            p = pinq.pop_front();
            chk(p.nm, p.got, p.want);
        end
    end

    // flags = {alu_mux_en, mem_to_reg, load_byte, store_byte, slt, u, read_next_pc, pc_add_write_value}
    function automatic logic [14:0] cw(input logic [3:0] alu, input logic [2:0] br,
                                       input logic [7:0] flags);
        return {alu, br, flags};
    endfunction

    task automatic pin(input string nm, input int got, input int want);
        pin_t p;
        p.nm = nm; p.got = got; p.want = want;
        pinq.push_back(p);
    endtask

    task automatic cycle(input logic fz, input logic ia, input logic da, input logic tc,
                         input logic [31:0] rd, input logic [2:0] st, input logic ireq,
                         input logic drd, input logic dwr, input logic rwe, input logic pce);
        exp_t e;
        @(posedge clk);
        #1;
        freeze = fz; bus.imem_ack = ia; bus.dmem_ack = da; trap_clear = tc; bus.imem_rdata = rd;
        e.st = st; e.ireq = ireq; e.drd = drd; e.dwr = dwr; e.rwe = rwe; e.pce = pce;
        e.ill = m_ill; e.be = m_be; e.cw = m_cw; e.ins = m_ins;
        expq.push_back(e);
    endtask

    task automatic do_reset();
        exp_t e;
        e = '0;
        @(posedge clk);
        #1;
        nRst = 1'b0; freeze = 1'b1; bus.imem_ack = 1'b0; bus.dmem_ack = 1'b0; trap_clear = 1'b0;
        m_cw = '0; m_ins = '0; m_ill = 1'b0; m_be = 1'b0;
        expq.push_back(e);
        @(posedge clk);
        #1;
        nRst = 1'b1;
        expq.push_back(e);
    endtask

    task automatic trap_wait(input logic stray);
        cycle(1'b0, stray, stray, 1'b0, 32'h0, S_TRAP, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, stray, stray, 1'b0, 32'h0, S_TRAP, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, stray, stray, 1'b1, 32'h0, S_TRAP, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        m_ill = 1'b0;
        m_be  = 1'b0;
    endtask

    // One instruction: optional freeze, fetch with iw wait cycles, decode, exec, optional
    // memory phase with dw wait cycles, writeback; waits >= TO mean the ack never comes.
    task automatic run_instr(input logic [31:0] w, input int kind, input logic [14:0] c,
                             input logic rw, input int fz, input int iw, input int dw,
                             input logic stray, input int rst_at, output int latency);
        int   n;
        logic ld, sto;
        ld = (kind == K_LD);
        sto = (kind == K_ST);
        latency = 0;
        for (int i = 0; i < fz; i++)
            cycle(1'b1, stray, stray, 1'b0, ~w, S_FETCH, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        n = (iw >= TO) ? TO : iw + 1;
        for (int i = 0; i < n; i++) begin
            cycle(1'b0, (i == iw), stray, 1'b0, (i == iw) ? w : ~w, S_FETCH,
                  1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
            latency++;
        end
        if (iw >= TO) begin
            m_be = 1'b1;
            trap_wait(stray);
            return;
        end
        m_ins = w;
        cycle(1'b0, stray, stray, 1'b0, ~w, S_DECODE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        latency++;
        if (kind == K_ILL) begin
            m_cw  = '0;
            m_ill = 1'b1;
            trap_wait(stray);
            return;
        end
        m_cw = c;
        cycle(1'b0, stray, stray, 1'b0, ~w, S_EXEC, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        latency++;
        if (ld || sto) begin
            n = (dw >= TO) ? TO : dw + 1;
            for (int i = 0; i < n; i++) begin
                if (i == rst_at) begin
                    do_reset();
                    return;
                end
                cycle(1'b0, stray, (i == dw), 1'b0, ~w, S_MEM, 1'b0, ld, sto, 1'b0, 1'b0);
                latency++;
            end
            if (dw >= TO) begin
                m_be = 1'b1;
                trap_wait(stray);
                return;
            end
        end
        cycle(1'b0, stray, stray, 1'b0, ~w, S_WB, 1'b0, 1'b0, 1'b0, rw, 1'b1);
        latency++;
    endtask

    initial begin
        nRst = 1'b0; freeze = 1'b1; trap_clear = 1'b0;
        bus.imem_ack = 1'b0; bus.dmem_ack = 1'b0; bus.imem_rdata = '0;
        m_cw = '0; m_ins = '0; m_ill = 1'b0; m_be = 1'b0;
        do_reset();

        run_instr(32'h00500093, K_ALU, cw(4'd0, 3'd0, 8'b1000_0000), 1'b1, 3, 0, 0, 1'b0, -1, lat);
        pin("lat_addi", lat, 4);
        run_instr(32'h0000A103, K_LD, cw(4'd0, 3'd0, 8'b1100_0000), 1'b1, 0, 0, 3, 1'b0, -1, lat);
        pin("lat_lw_3wait", lat, 8);
        run_instr(32'h0020A023, K_ST, cw(4'd0, 3'd0, 8'b1000_0000), 1'b0, 0, 0, 1, 1'b1, -1, lat);
        pin("lat_sw_1wait", lat, 6);
        run_instr(32'h402081B3, K_ALU, cw(4'd1, 3'd0, 8'b0000_0000), 1'b1, 0, 1, 0, 1'b0, -1, lat);
        run_instr(32'h0020B1B3, K_ALU, cw(4'd1, 3'd0, 8'b0000_1100), 1'b1, 0, 0, 0, 1'b0, -1, lat);
        run_instr(32'h4020D193, K_ALU, cw(4'd7, 3'd0, 8'b1000_0000), 1'b1, 0, 0, 0, 1'b1, -1, lat);
        run_instr(32'h0020D193, K_ALU, cw(4'd6, 3'd0, 8'b1000_0000), 1'b1, 0, 0, 0, 1'b0, -1, lat);
        run_instr(32'h40209193, K_ALU, cw(4'd5, 3'd0, 8'b1000_0000), 1'b1, 0, 0, 0, 1'b0, -1, lat);
        run_instr(32'h123452B7, K_ALU, cw(4'd8, 3'd0, 8'b1000_0000), 1'b1, 0, 0, 0, 1'b0, -1, lat);
        run_instr(32'h00001297, K_ALU, cw(4'd0, 3'd0, 8'b1000_0011), 1'b1, 0, 0, 0, 1'b0, -1, lat);
        run_instr(32'h0020E063, K_ALU, cw(4'd1, 3'd5, 8'b0000_0100), 1'b0, 0, 0, 0, 1'b1, -1, lat);
        run_instr(32'h000000EF, K_ALU, cw(4'd0, 3'd7, 8'b0000_0010), 1'b1, 0, 0, 0, 1'b0, -1, lat);
        run_instr(32'h000100E7, K_ALU, cw(4'd0, 3'd7, 8'b1000_0011), 1'b1, 0, 0, 0, 1'b0, -1, lat);
        run_instr(32'h00008103, K_LD, cw(4'd0, 3'd0, 8'b1110_0000), 1'b1, 0, 0, 0, 1'b0, -1, lat);
        pin("lat_lb_0wait", lat, 5);
        run_instr(32'h00208023, K_ST, cw(4'd0, 3'd0, 8'b1001_0000), 1'b0, 0, 0, 0, 1'b0, -1, lat);
        run_instr(32'hFFFFFFFF, K_ILL, '0, 1'b0, 0, 0, 0, 1'b1, -1, lat);
        run_instr(32'h4020C1B3, K_ILL, '0, 1'b0, 0, 0, 0, 1'b0, -1, lat);
        run_instr(32'h00500093, K_ALU, cw(4'd0, 3'd0, 8'b1000_0000), 1'b1, 0, TO, 0, 1'b0, -1, lat);
        run_instr(32'h00500093, K_ALU, cw(4'd0, 3'd0, 8'b1000_0000), 1'b1, 0, TO - 1, 0, 1'b0, -1, lat);
        pin("lat_addi_ack_at_limit", lat, 7);
        run_instr(32'h0020A023, K_ST, cw(4'd0, 3'd0, 8'b1000_0000), 1'b0, 0, 0, TO, 1'b0, -1, lat);
        run_instr(32'h0000A103, K_LD, cw(4'd0, 3'd0, 8'b1100_0000), 1'b1, 0, 0, 3, 1'b0, 1, lat);
        run_instr(32'h00500093, K_ALU, cw(4'd0, 3'd0, 8'b1000_0000), 1'b1, 1, 0, 0, 1'b0, -1, lat);

        @(posedge clk);
        #1;
        freeze = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within the time limit");
        $fatal(1);
    end
endmodule
